// File: rtl/fft_butterfly_if.sv
// Operand/result bus of the radix-2 butterfly, plus the twiddle ROM lookup.
// The ROM is outside the block, so it gets its own modport.
interface fft_butterfly_if #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int IDX_W  = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a_re, in_a_im;
  logic signed [DATA_W-1:0] in_b_re, in_b_im;
  logic        [IDX_W-1:0]  in_k;
  logic                     in_scale;

  logic        [IDX_W-1:0]  tw_idx;
  logic signed [TW_W-1:0]   tw_re, tw_im;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_x_re, out_x_im;
  logic signed [DATA_W-1:0] out_y_re, out_y_im;
  logic                     sat_flag;
  logic                     clr_sat;

  // Upstream sequencer + downstream write-back side
  modport master (
    output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_k, in_scale,
    output out_ready, clr_sat,
    input  in_ready, out_valid, out_x_re, out_x_im, out_y_re, out_y_im, sat_flag
  );

  // Twiddle ROM: combinational lookup
  modport rom (
    input  tw_idx,
    output tw_re, tw_im
  );

  // The butterfly itself
  modport slave (
    input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_k, in_scale,
    input  out_ready, clr_sat, tw_re, tw_im,
    output in_ready, tw_idx, out_valid, out_x_re, out_x_im, out_y_re, out_y_im,
    output sat_flag
  );
endinterface

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: X = a + b*W, Y = a - b*W with Q2.14 twiddles.
// Three register stages (capture, complex multiply + round, add/scale/saturate)
// under a single global enable, so backpressure freezes the whole pipe.

// One output component: a +/- t, optional halving (round half-up), clamp.
module fft_bfly_lane #(
  parameter int DATA_W = 16,
  parameter int T_W    = 18
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [T_W-1:0]    t_i,
  input  logic                     sub_i,
  input  logic                     scale_i,
  output logic signed [DATA_W-1:0] s_o,
  output logic                     sat_o
);
  localparam int S_W = T_W + 1;
  localparam logic signed [S_W-1:0] S_MAX = S_W'(2**(DATA_W-1) - 1);
  localparam logic signed [S_W-1:0] S_MIN = ~S_MAX;
  localparam logic signed [S_W-1:0] ONE   = S_W'(1);

  logic signed [S_W-1:0] a_x, t_x, sum, scl;

  // Widen, add/sub, optional /2, then clamp to the output range
  always_comb begin
    a_x   = {{(S_W-DATA_W){a_i[DATA_W-1]}}, a_i};
    t_x   = {t_i[T_W-1], t_i};
    sum   = sub_i ? (a_x - t_x) : (a_x + t_x);
    scl   = scale_i ? ((sum + ONE) >>> 1) : sum;
    sat_o = 1'b0;
    s_o   = scl[DATA_W-1:0];
    if (scl > S_MAX) begin
      s_o   = S_MAX[DATA_W-1:0];
      sat_o = 1'b1;
    end else if (scl < S_MIN) begin
      s_o   = S_MIN[DATA_W-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

module fft_butterfly #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int IDX_W  = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  fft_butterfly_if.slave  bus
);
  localparam int STAGES    = 3;
  localparam int FRAC      = 14;
  localparam int PROD_W    = DATA_W + TW_W;
  localparam int SUM_W     = PROD_W + 1;
  localparam int T_W       = DATA_W + 2;
  localparam int NUM_LANES = 4;   // x_re, x_im, y_re, y_im
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(2**(FRAC-1));

  logic              en;
  logic [STAGES:1]   vld_pipe_q;

  // stage 1: captured operands and twiddle
  logic signed [DATA_W-1:0] a_re_q1, a_im_q1, b_re_q1, b_im_q1;
  logic signed [TW_W-1:0]   w_re_q1, w_im_q1;
  logic                     scale_q1;

  // stage 2: rounded product t = b*W and pass-through a
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SUM_W-1:0]  t_re_full, t_im_full, t_re_sh, t_im_sh;
  logic signed [T_W-1:0]    t_re_q2, t_im_q2;
  logic signed [DATA_W-1:0] a_re_q2, a_im_q2;
  logic                     scale_q2;

  // stage 3: per-lane results
  logic [NUM_LANES-1:0][DATA_W-1:0] a_l, s_l, out_q;
  logic [NUM_LANES-1:0][T_W-1:0]    t_l;
  logic [NUM_LANES-1:0]             sat_l;
  logic                             sat_set, sat_d, sat_q;

  // A stalled output freezes every stage; bubbles travel with the data
  assign en           = !vld_pipe_q[STAGES] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.tw_idx   = bus.in_k;
  assign bus.out_valid = vld_pipe_q[STAGES];

  // Valid shift register, advancing only when the pipe moves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vld_pipe_q <= '0;
    else if (en)   vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
  end

  // Stage 1: capture operands and the ROM's same-cycle twiddle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_re_q1 <= '0; a_im_q1 <= '0; b_re_q1 <= '0; b_im_q1 <= '0;
      w_re_q1 <= '0; w_im_q1 <= '0; scale_q1 <= 1'b0;
    end else if (en) begin
      a_re_q1  <= bus.in_a_re;
      a_im_q1  <= bus.in_a_im;
      b_re_q1  <= bus.in_b_re;
      b_im_q1  <= bus.in_b_im;
      w_re_q1  <= bus.tw_re;
      w_im_q1  <= bus.tw_im;
      scale_q1 <= bus.in_scale;
    end
  end

  // Complex multiply at full width, then round-half-up back to integer scale
  assign p_rr = b_re_q1 * w_re_q1;
  assign p_ii = b_im_q1 * w_im_q1;
  assign p_ri = b_re_q1 * w_im_q1;
  assign p_ir = b_im_q1 * w_re_q1;

  assign t_re_full = $signed({p_rr[PROD_W-1], p_rr}) - $signed({p_ii[PROD_W-1], p_ii});
  assign t_im_full = $signed({p_ri[PROD_W-1], p_ri}) + $signed({p_ir[PROD_W-1], p_ir});
  assign t_re_sh   = (t_re_full + RND) >>> FRAC;
  assign t_im_sh   = (t_im_full + RND) >>> FRAC;

  // Stage 2: keep 18 bits of t; |b*W| cannot exceed that range
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_re_q2 <= '0; t_im_q2 <= '0; a_re_q2 <= '0; a_im_q2 <= '0;
      scale_q2 <= 1'b0;
    end else if (en) begin
      t_re_q2  <= t_re_sh[T_W-1:0];
      t_im_q2  <= t_im_sh[T_W-1:0];
      a_re_q2  <= a_re_q1;
      a_im_q2  <= a_im_q1;
      scale_q2 <= scale_q1;
    end
  end

  // Lanes 0/1 add (X), lanes 2/3 subtract (Y)
  assign a_l = {a_im_q2, a_re_q2, a_im_q2, a_re_q2};
  assign t_l = {t_im_q2, t_re_q2, t_im_q2, t_re_q2};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fft_bfly_lane #(.DATA_W(DATA_W), .T_W(T_W)) u_lane (
      .a_i     (a_l[i]),
      .t_i     (t_l[i]),
      .sub_i   (i >= 2),
      .scale_i (scale_q2),
      .s_o     (s_l[i]),
      .sat_o   (sat_l[i])
    );
  end

  // Stage 3: register results; held while downstream stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  out_q <= '0;
    else if (en)   out_q <= s_l;
  end

  // Sticky saturation: a set in the same cycle as a clear takes priority
  assign sat_set = en && vld_pipe_q[STAGES-1] && (|sat_l);
  assign sat_d   = sat_set ? 1'b1 : (bus.clr_sat ? 1'b0 : sat_q);

  // Saturation flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  sat_q <= 1'b0;
    else           sat_q <= sat_d;
  end

  assign bus.out_x_re = out_q[0];
  assign bus.out_x_im = out_q[1];
  assign bus.out_y_re = out_q[2];
  assign bus.out_y_im = out_q[3];
  assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly: accepted operands are modelled with
// plain integer arithmetic and queued; a monitor pops and compares outputs.
module tb_fft_butterfly;
  localparam int DATA_W = 16, TW_W = 16, IDX_W = 6;

  typedef struct { int xr; int xi; int yr; int yi; bit sat; } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_butterfly_if #(.DATA_W(DATA_W), .TW_W(TW_W), .IDX_W(IDX_W)) bif();
  fft_butterfly #(.DATA_W(DATA_W), .TW_W(TW_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif)
  );

  // Twiddle ROM: W(k) = cos(2*pi*k/64) - j*sin(2*pi*k/64) in Q2.14
  int rom_re[64], rom_im[64];
  assign bif.tw_re = TW_W'(rom_re[bif.tw_idx]);
  assign bif.tw_im = TW_W'(rom_im[bif.tw_idx]);

  exp_t sb[$];
  int   total = 0, bad = 0, acc_cnt = 0;
  bit   rnd_bp = 1'b0, sat_seen = 1'b0, held = 1'b0;
  int   hold_v[4];

  function automatic longint fdiv(longint n, longint d);
    longint q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(int ar, int ai, int br, int bi, int k, bit sc);
    exp_t   e;
    longint wr = rom_re[k], wi = rom_im[k];
    longint tr, ti;
    longint s[4];
    tr = fdiv(br * wr - bi * wi + 8192, 16384);
    ti = fdiv(br * wi + bi * wr + 8192, 16384);
    s[0] = ar + tr; s[1] = ai + ti; s[2] = ar - tr; s[3] = ai - ti;
    e.sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sc) s[i] = fdiv(s[i] + 1, 2);
      if (s[i] > 32767)  begin s[i] = 32767;  e.sat = 1'b1; end
      if (s[i] < -32768) begin s[i] = -32768; e.sat = 1'b1; end
    end
    e.xr = int'(s[0]); e.xi = int'(s[1]); e.yr = int'(s[2]); e.yi = int'(s[3]);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Accept side: an operand set handshaken now enters at the next edge
  always @(negedge clk) begin
    if (reset_n && bif.in_valid && bif.in_ready) begin
      sb.push_back(model(int'(bif.in_a_re), int'(bif.in_a_im), int'(bif.in_b_re),
                         int'(bif.in_b_im), int'(bif.in_k), bif.in_scale));
      acc_cnt++;
    end
  end

  // Output side: handshake rule, stall stability, in-order results
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready_rule", int'(bif.in_ready), int'(!bif.out_valid || bif.out_ready));
      if (held && bif.out_valid) begin
        chk("hold_x_re", int'(bif.out_x_re), hold_v[0]);
        chk("hold_y_im", int'(bif.out_y_im), hold_v[3]);
      end
      held = 1'b0;
      if (bif.out_valid && !bif.out_ready) begin
        held = 1'b1;
        hold_v[0] = int'(bif.out_x_re); hold_v[3] = int'(bif.out_y_im);
      end
      if (bif.out_valid && bif.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("x_re", int'(bif.out_x_re), e.xr);
          chk("x_im", int'(bif.out_x_im), e.xi);
          chk("y_re", int'(bif.out_y_re), e.yr);
          chk("y_im", int'(bif.out_y_im), e.yi);
          if (e.sat) sat_seen = 1'b1;
        end
      end
    end
  end

  // Random downstream backpressure
  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      if (rnd_bp) bif.out_ready = 1'($urandom % 2);
    end
  end

  // Present one operand set and hold it until accepted (bounded)
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int k, input bit sc);
    int n = 0;
    bif.in_a_re = 16'(ar); bif.in_a_im = 16'(ai);
    bif.in_b_re = 16'(br); bif.in_b_im = 16'(bi);
    bif.in_k = 6'(k); bif.in_scale = sc; bif.in_valid = 1'b1;
    @(negedge clk);
    while (!bif.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_left", sb.size(), 0);
    @(negedge clk);
  endtask

  // Accept at edge A: out_valid low after A and A+1, high after A+2
  task automatic latency_check(input string tag);
    @(negedge clk); chk({tag, "_ov_a"}, int'(bif.out_valid), 0);
    @(negedge clk); chk({tag, "_ov_b"}, int'(bif.out_valid), 0);
    @(negedge clk); chk({tag, "_ov_c"}, int'(bif.out_valid), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base;
    bit bp_done;
    for (int k = 0; k < 64; k++) begin
      rom_re[k] = int'($cos(2.0 * 3.14159265358979 * k / 64.0) * 16384.0);
      rom_im[k] = -int'($sin(2.0 * 3.14159265358979 * k / 64.0) * 16384.0);
    end
    bif.in_valid = 1'b0; bif.in_a_re = '0; bif.in_a_im = '0; bif.in_b_re = '0;
    bif.in_b_im = '0; bif.in_k = '0; bif.in_scale = 1'b0;
    bif.out_ready = 1'b1; bif.clr_sat = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bif.out_valid), 0);
    chk("rst_x_re", int'(bif.out_x_re), 0);
    chk("rst_y_im", int'(bif.out_y_im), 0);
    chk("rst_sat", int'(bif.sat_flag), 0);
    bif.in_k = 6'd37;
    #1 chk("tw_idx_follows_k", int'(bif.tw_idx), 37);
    reset_n = 1'b1;

    // Directed cases: W=1, W=-j, W=e^{-j pi/4}, index 63
    send(1000, 0, 200, 0, 0, 1'b0);
    latency_check("lat1");
    drain();
    chk("sat_clear_after_plain", int'(bif.sat_flag), 0);
    send(0, 0, 100, 0, 16, 1'b0); drain();
    send(0, 0, 1, 0, 8, 1'b0);    drain();
    send(-500, 300, 1200, -700, 63, 1'b0); drain();

    // Saturation, sticky flag, clear, then the scaled version stays in range
    send(32767, 0, 32767, 0, 0, 1'b0); drain();
    chk("sat_set", int'(bif.sat_flag), 1);
    @(posedge clk); #1 bif.clr_sat = 1'b1;
    @(posedge clk); #1 bif.clr_sat = 1'b0;
    chk("sat_cleared", int'(bif.sat_flag), 0);
    send(32767, 0, 32767, 0, 0, 1'b1); drain();
    chk("sat_scaled_none", int'(bif.sat_flag), 0);

    // Set beats a clear held in the same cycle
    bif.clr_sat = 1'b1;
    send(-32768, 0, 32767, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("set_wins_ov", int'(bif.out_valid), 1);
    chk("set_wins_flag", int'(bif.sat_flag), 1);
    @(negedge clk);
    chk("clr_after_set", int'(bif.sat_flag), 0);
    #1 bif.clr_sat = 1'b0;
    drain();

    // Backpressure: 4 back-to-back with out_ready low; only 3 fit
    @(posedge clk); #1 bif.out_ready = 1'b0;
    base = acc_cnt; bp_done = 1'b0;
    fork
      begin
        send(100, 1, 10, 2, 0, 1'b0);
        send(200, 3, 20, 4, 4, 1'b0);
        send(300, 5, 30, 6, 12, 1'b1);
        send(400, 7, 40, 8, 20, 1'b0);
        bp_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    chk("bp_accepted", acc_cnt - base, 3);
    chk("bp_in_ready", int'(bif.in_ready), 0);
    chk("bp_out_valid", int'(bif.out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 bif.out_ready = ~bif.out_ready;
    end
    @(posedge clk); #1 bif.out_ready = 1'b1;
    for (int i = 0; i < 200 && !bp_done; i++) @(negedge clk);
    chk("bp_sender_done", int'(bp_done), 1);
    drain();
    chk("bp_total", acc_cnt - base, 4);

    // Reset with work in flight: nothing from before may appear afterwards
    send(1111, -222, 333, 44, 5, 1'b0);
    send(500, 500, 500, 500, 9, 1'b0);
    send(-700, 60, 80, -90, 33, 1'b1);
    sb.delete();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ov", int'(bif.out_valid), 0);
    chk("mid_rst_x_re", int'(bif.out_x_re), 0);
    chk("mid_rst_x_im", int'(bif.out_x_im), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    send(250, -250, 90, 45, 48, 1'b0);
    latency_check("lat2");
    drain();

    // Randomized traffic with random stalls
    @(posedge clk); #1 bif.clr_sat = 1'b1;
    @(posedge clk); #1 bif.clr_sat = 1'b0;
    sat_seen = 1'b0;
    rnd_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom % 2) @(posedge clk);
      #0;
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
           int'($signed(16'($urandom))), int'($signed(16'($urandom))),
           int'($urandom % 64), 1'($urandom % 2));
    end
    rnd_bp = 1'b0;
    @(posedge clk); #2 bif.out_ready = 1'b1;
    drain();
    chk("rand_sat_flag", int'(bif.sat_flag), int'(sat_seen));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
